// File: rtl/usb_tx_sched.sv
// usb_tx_sched: arbitrates handshake and data packets onto the usb_tx byte interface with an enforced inter-packet gap
module usb_tx_sched #(
  parameter int MAX_LEN  = 64,
  parameter int LEN_W    = 7,
  parameter int GAP_CLKS = 16
) (
  input  logic             clk_48,
  input  logic             rst,
  input  logic             hs_req,
  input  logic [1:0]       hs_pid,
  input  logic             dat_req,
  input  logic             dat_toggle,
  input  logic [LEN_W-1:0] dat_len,
  output logic [LEN_W-1:0] buf_addr,
  input  logic [7:0]       buf_data,
  output logic             hs_done,
  output logic             dat_done,
  output logic             busy,
  output logic             transmit,
  output logic [7:0]       data,
  output logic             update_crc16,
  output logic             send_crc16,
  input  logic             data_strobe,
  input  logic             tx_en
);
  localparam int GAP_W = $clog2(GAP_CLKS + 1);
  typedef enum logic [1:0] {S_IDLE, S_PID, S_PAYLOAD, S_END} state_e;
  state_e           state_q;
  logic             is_hs_q, transmit_q, send_crc_q, busy_q, hs_done_q, dat_done_q;
  logic [7:0]       pid_q, pid_d;
  logic [LEN_W-1:0] cnt_q, buf_addr_q, len_d;
  logic [GAP_W-1:0] gap_q;
  // PID byte for the class that would win a grant now, and the clamped payload length
  always_comb begin
    pid_d = hs_req ? (hs_pid == 2'd0 ? 8'hD2 : hs_pid == 2'd1 ? 8'h5A : 8'h1E)
                   : (dat_toggle ? 8'h4B : 8'hC3);
    len_d = dat_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : dat_len;
  end
  // Packet sequencer: grant, PID, payload bytes, then wait for the serializer to finish CRC and EOP
  always_ff @(posedge clk_48) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_hs_q    <= 1'b0;
      pid_q      <= 8'h00;
      cnt_q      <= '0;
      buf_addr_q <= '0;
      gap_q      <= '0;
      transmit_q <= 1'b0;
      send_crc_q <= 1'b0;
      busy_q     <= 1'b0;
      hs_done_q  <= 1'b0;
      dat_done_q <= 1'b0;
    end else begin
      hs_done_q  <= 1'b0;
      dat_done_q <= 1'b0;
      case (state_q)
        S_IDLE:
          if (gap_q != '0) gap_q <= gap_q - 1'b1;
          else if (!tx_en && (hs_req || dat_req)) begin
            is_hs_q    <= hs_req;
            pid_q      <= pid_d;
            cnt_q      <= hs_req ? '0 : len_d;
            buf_addr_q <= '0;
            busy_q     <= 1'b1;
            transmit_q <= 1'b1;
            send_crc_q <= !hs_req;
            state_q    <= S_PID;
          end
        S_PID:
          if (data_strobe) begin
            if (is_hs_q || cnt_q == '0) begin
              transmit_q <= 1'b0;
              state_q    <= S_END;
            end else state_q <= S_PAYLOAD;
          end
        S_PAYLOAD:
          if (data_strobe) begin
            cnt_q      <= cnt_q - 1'b1;
            buf_addr_q <= buf_addr_q + 1'b1;
            if (cnt_q == LEN_W'(1)) begin
              transmit_q <= 1'b0;
              state_q    <= S_END;
            end
          end
        S_END:
          if (!tx_en) begin
            hs_done_q  <= is_hs_q;
            dat_done_q <= !is_hs_q;
            busy_q     <= 1'b0;
            send_crc_q <= 1'b0;
            gap_q      <= GAP_W'(GAP_CLKS);
            state_q    <= S_IDLE;
          end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign data         = state_q == S_PID ? pid_q : state_q == S_PAYLOAD ? buf_data : 8'h00;
  assign update_crc16 = state_q == S_PAYLOAD;
  assign send_crc16   = send_crc_q;
  assign transmit     = transmit_q;
  assign busy         = busy_q;
  assign hs_done      = hs_done_q;
  assign dat_done     = dat_done_q;
  assign buf_addr     = buf_addr_q;
endmodule

// File: tb/tb_usb_tx_sched.sv
// tb_usb_tx_sched: directed checks of grant, sequencing, gap, clamping and reset for usb_tx_sched
module tb_usb_tx_sched;
  localparam int GAP = 16;
  logic       clk_48 = 1'b0, rst = 1'b1;
  logic       hs_req = 1'b0, dat_req = 1'b0, dat_toggle = 1'b0, data_strobe = 1'b0, tx_en = 1'b0;
  logic [1:0] hs_pid = 2'd0;
  logic [6:0] dat_len = 7'd0, buf_addr;
  logic [7:0] buf_data = 8'h00, data;
  logic       hs_done, dat_done, busy, transmit, update_crc16, send_crc16;
  logic [7:0] mem [0:127];
  logic [13:0] obs;
  int tests = 0, fails = 0;

  usb_tx_sched dut (
    .clk_48(clk_48), .rst(rst), .hs_req(hs_req), .hs_pid(hs_pid), .dat_req(dat_req),
    .dat_toggle(dat_toggle), .dat_len(dat_len), .buf_addr(buf_addr), .buf_data(buf_data),
    .hs_done(hs_done), .dat_done(dat_done), .busy(busy), .transmit(transmit), .data(data),
    .update_crc16(update_crc16), .send_crc16(send_crc16), .data_strobe(data_strobe), .tx_en(tx_en)
  );

  always #5 clk_48 = ~clk_48;
  always @(posedge clk_48) buf_data <= mem[buf_addr];
  // observed bundle: busy, transmit, update_crc16, send_crc16, hs_done, dat_done, data
  assign obs = {busy, transmit, update_crc16, send_crc16, hs_done, dat_done, data};

  task automatic tick;
    @(posedge clk_48);
    #1;
  endtask

  task automatic strobe;
    data_strobe = 1'b1;
    tick();
    data_strobe = 1'b0;
  endtask

  task automatic test_reset;
    logic [13:0] e;
    rst = 1'b1;
    tick();
    tick();
    e = 14'h0;
    tests++; if (obs !== e) begin fails++; $display("FAIL reset obs=%h exp=%h", obs, e); end
    tests++; if (buf_addr !== 7'd0) begin fails++; $display("FAIL reset_addr got=%0d exp=0", buf_addr); end
    rst = 1'b0;
    strobe();
    tick();
    tests++; if (obs !== e) begin fails++; $display("FAIL idle_strobe obs=%h exp=%h", obs, e); end
  endtask

  task automatic send_hs(input logic [1:0] pid, input logic [7:0] pb);
    logic [13:0] e;
    hs_pid = pid;
    hs_req = 1'b1;
    tick();
    e = {6'b110000, pb};
    tests++; if (obs !== e) begin fails++; $display("FAIL hs_grant pid=%0d obs=%h exp=%h", pid, obs, e); end
    tx_en = 1'b1;
    tick();
    tick();
    tests++; if (obs !== e) begin fails++; $display("FAIL hs_hold obs=%h exp=%h", obs, e); end
    strobe();
    e = {6'b100000, 8'h00};
    tests++; if (obs !== e) begin fails++; $display("FAIL hs_end obs=%h exp=%h", obs, e); end
    tick();
    tests++; if (obs !== e) begin fails++; $display("FAIL hs_wait obs=%h exp=%h", obs, e); end
    tx_en = 1'b0;
    tick();
    e = {6'b000010, 8'h00};
    tests++; if (obs !== e) begin fails++; $display("FAIL hs_done obs=%h exp=%h", obs, e); end
    hs_req = 1'b0;
    tick();
    e = 14'h0;
    tests++; if (obs !== e) begin fails++; $display("FAIL hs_pulse obs=%h exp=%h", obs, e); end
    repeat (GAP + 2) tick();
  endtask

  task automatic test_handshake;
    send_hs(2'd0, 8'hD2);
    send_hs(2'd1, 8'h5A);
    send_hs(2'd2, 8'h1E);
    send_hs(2'd3, 8'h1E);
  endtask

  task automatic test_data(input logic tog, input logic [6:0] len, input int n);
    logic [13:0] e;
    dat_toggle = tog;
    dat_len = len;
    dat_req = 1'b1;
    tick();
    e = {6'b110100, tog ? 8'h4B : 8'hC3};
    tests++; if (obs !== e) begin fails++; $display("FAIL dat_grant obs=%h exp=%h", obs, e); end
    tests++; if (buf_addr !== 7'd0) begin fails++; $display("FAIL dat_addr0 got=%0d exp=0", buf_addr); end
    tx_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      strobe();
      tick();
      e = {6'b111100, mem[i]};
      tests++; if (obs !== e) begin fails++; $display("FAIL dat_byte i=%0d obs=%h exp=%h", i, obs, e); end
      tests++; if (buf_addr !== 7'(i)) begin fails++; $display("FAIL dat_addr i=%0d got=%0d exp=%0d", i, buf_addr, i); end
    end
    strobe();
    e = {6'b100100, 8'h00};
    tests++; if (obs !== e) begin fails++; $display("FAIL dat_end obs=%h exp=%h", obs, e); end
    tests++; if (buf_addr !== 7'(n)) begin fails++; $display("FAIL dat_addr_end got=%0d exp=%0d", buf_addr, n); end
    tx_en = 1'b0;
    tick();
    e = {6'b000001, 8'h00};
    tests++; if (obs !== e) begin fails++; $display("FAIL dat_done obs=%h exp=%h", obs, e); end
    dat_req = 1'b0;
    tick();
    e = 14'h0;
    tests++; if (obs !== e) begin fails++; $display("FAIL dat_pulse obs=%h exp=%h", obs, e); end
    repeat (GAP + 2) tick();
  endtask

  task automatic test_priority;
    logic [13:0] e;
    hs_pid = 2'd1;
    dat_toggle = 1'b0;
    dat_len = 7'd0;
    hs_req = 1'b1;
    dat_req = 1'b1;
    tick();
    e = {6'b110000, 8'h5A};
    tests++; if (obs !== e) begin fails++; $display("FAIL prio_grant obs=%h exp=%h", obs, e); end
    tx_en = 1'b1;
    strobe();
    tx_en = 1'b0;
    tick();
    e = {6'b000010, 8'h00};
    tests++; if (obs !== e) begin fails++; $display("FAIL prio_hs_done obs=%h exp=%h", obs, e); end
    hs_req = 1'b0;
    for (int k = 1; k <= GAP; k++) begin
      tick();
      tests++; if (transmit !== 1'b0) begin fails++; $display("FAIL gap_early k=%0d transmit=%b exp=0", k, transmit); end
    end
    tick();
    e = {6'b110100, 8'hC3};
    tests++; if (obs !== e) begin fails++; $display("FAIL gap_grant obs=%h exp=%h", obs, e); end
    tx_en = 1'b1;
    strobe();
    tx_en = 1'b0;
    tick();
    e = {6'b000001, 8'h00};
    tests++; if (obs !== e) begin fails++; $display("FAIL prio_dat_done obs=%h exp=%h", obs, e); end
    dat_req = 1'b0;
    repeat (GAP + 2) tick();
  endtask

  task automatic test_reset_mid;
    logic [13:0] e;
    dat_toggle = 1'b1;
    dat_len = 7'd3;
    dat_req = 1'b1;
    tick();
    tx_en = 1'b1;
    strobe();
    strobe();
    tests++; if (buf_addr !== 7'd1) begin fails++; $display("FAIL mid_addr got=%0d exp=1", buf_addr); end
    rst = 1'b1;
    tick();
    e = 14'h0;
    tests++; if (obs !== e) begin fails++; $display("FAIL mid_reset obs=%h exp=%h", obs, e); end
    tests++; if (buf_addr !== 7'd0) begin fails++; $display("FAIL mid_reset_addr got=%0d exp=0", buf_addr); end
    rst = 1'b0;
    dat_req = 1'b0;
    tx_en = 1'b0;
    tick();
    tests++; if (obs !== e) begin fails++; $display("FAIL mid_no_done obs=%h exp=%h", obs, e); end
    hs_pid = 2'd2;
    hs_req = 1'b1;
    tick();
    e = {6'b110000, 8'h1E};
    tests++; if (obs !== e) begin fails++; $display("FAIL mid_regrant obs=%h exp=%h", obs, e); end
    tx_en = 1'b1;
    strobe();
    tx_en = 1'b0;
    tick();
    e = {6'b000010, 8'h00};
    tests++; if (obs !== e) begin fails++; $display("FAIL mid_hs_done obs=%h exp=%h", obs, e); end
    hs_req = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'((i + 1) * 17);
    test_reset();
    test_handshake();
    test_data(1'b1, 7'd3, 3);
    test_data(1'b0, 7'd0, 0);
    test_priority();
    test_data(1'b0, 7'd100, 64);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
